// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states
// and the idle byte-lane mask.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic [7:0] WMASK_NONE = 8'h00;

  // A request is rejected without touching the sram when it is contradictory,
  // uses the reserved size, or is not naturally aligned for its size.
  function automatic logic req_illegal(input logic ren, input logic wen,
                                       input logic [1:0] size,
                                       input logic [1:0] off);
    req_illegal = (ren && wen)
               || (size == SZ_RSV)
               || (size == SZ_H && off[0])
               || (size == SZ_W && off != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the three LSU links: request from execute, response to writeback,
// and the data sram port. master = surrounding pipeline/sram, slave = LSU.
interface lsu_if;
  import lsu_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic        in_ren;
  logic        in_wen;
  logic [1:0]  in_size;
  logic        in_signed;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  logic        sram_ren;
  logic        sram_wen;
  logic [7:0]  sram_wmask;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_data;
  logic        sram_valid;

  modport master (
    output in_valid, in_ren, in_wen, in_size, in_signed, in_addr, in_wdata,
    input  in_ready,
    input  out_valid, out_rdata, out_err,
    output out_ready,
    input  sram_ren, sram_wen, sram_wmask, sram_addr, sram_wdata,
    output sram_data, sram_valid
  );

  modport slave (
    input  in_valid, in_ren, in_wen, in_size, in_signed, in_addr, in_wdata,
    output in_ready,
    output out_valid, out_rdata, out_err,
    input  out_ready,
    output sram_ren, sram_wen, sram_wmask, sram_addr, sram_wdata,
    input  sram_data, sram_valid
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: replicates store data across byte lanes with the
// matching write mask, and extracts/extends the addressed field of a load word.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        sign,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [7:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_field;
  logic [15:0] half_field;

  assign byte_field = load_raw[{off, 3'b000} +: 8];
  assign half_field = load_raw[{off[1], 4'b0000} +: 16];

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wmask     = WMASK_NONE;
    wdata     = store_data;
    load_data = '0;
    unique case (size)
      SZ_B: begin
        wmask     = 8'h01 << off;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{sign & byte_field[7]}}, byte_field};
      end
      SZ_H: begin
        wmask     = 8'h03 << off;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{sign & half_field[15]}}, half_field};
      end
      SZ_W: begin
        wmask     = 8'h0F;
        wdata     = store_data;
        load_data = load_raw;
      end
      default: begin
        wmask     = WMASK_NONE;
        wdata     = store_data;
        load_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one op per handshake, drives the data sram until it
// completes or times out, then holds a single response until writeback takes it.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic  clk,
  input  logic  rst,
  lsu_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic               resp_err;
  logic [31:0]        resp_rdata;

  logic [31:0]        req_addr;
  size_e              req_size;
  logic               req_signed;
  logic [31:0]        req_wdata;

  logic [7:0]         lane_wmask;
  logic [31:0]        lane_wdata;
  logic [31:0]        load_data;
  logic               illegal;
  logic               valid_seen;
  logic               timed_out;

  lsu_align u_align (
    .size       (req_size),
    .off        (req_addr[1:0]),
    .sign       (req_signed),
    .store_data (req_wdata),
    .load_raw   (bus.sram_data),
    .wmask      (lane_wmask),
    .wdata      (lane_wdata),
    .load_data  (load_data)
  );

  assign illegal    = req_illegal(bus.in_ren, bus.in_wen, bus.in_size, bus.in_addr[1:0]);
  // The first wait cycle never completes: sram_valid only counts once cnt > 0.
  assign valid_seen = bus.sram_valid && (cnt != '0);
  assign timed_out  = (cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register in
  // this block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.in_valid) begin
            if (illegal) begin
              state      <= RESP;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (bus.in_ren) begin
              state <= RD_WAIT;
            end else if (bus.in_wen) begin
              state <= WR_WAIT;
            end else begin
              state      <= RESP;
              resp_err   <= 1'b0;
              resp_rdata <= '0;
            end
          end
        end
        RD_WAIT, WR_WAIT: begin
          cnt <= cnt + 1'b1;
          if (valid_seen) begin
            state      <= RESP;
            resp_err   <= 1'b0;
            resp_rdata <= (state == RD_WAIT) ? load_data : '0;
          end else if (timed_out) begin
            state      <= RESP;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        RESP: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the request registers are plain datapath and are only observed in
  // the wait states after an accept has loaded them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      req_addr   <= bus.in_addr;
      req_size   <= size_e'(bus.in_size);
      req_signed <= bus.in_signed;
      req_wdata  <= bus.in_wdata;
    end
  end

  // Outputs are gated by rst so the idle values hold during any reset cycle,
  // not only from the edge after it.
  assign bus.in_ready   = rst || (state == IDLE);
  assign bus.out_valid  = !rst && (state == RESP);
  assign bus.out_err    = !rst && (state == RESP) && resp_err;
  assign bus.out_rdata  = (!rst && state == RESP) ? resp_rdata : '0;

  assign bus.sram_ren   = !rst && (state == RD_WAIT);
  assign bus.sram_wen   = !rst && (state == WR_WAIT);
  assign bus.sram_wmask = bus.sram_wen ? lane_wmask : WMASK_NONE;
  assign bus.sram_addr  = {req_addr[31:2], 2'b00};
  assign bus.sram_wdata = lane_wdata;

endmodule
